// File: rtl/rd_ptr_ctrl_if.sv
// rtl/rd_ptr_ctrl_if.sv - read-side signal bundle for the FIFO read-pointer controller
//
// Purpose: groups the read request, synchronised write pointer, error clear and
// all read-side status/pointer outputs of rd_ptr_ctrl.
// Ports (signals):
//   r_en            read request                       (master -> slave)
//   wptr_gray_sync  Gray write pointer, in r_clk       (master -> slave)
//   clr_err         clear sticky underflow             (master -> slave)
//   raddr           RAM read address                   (slave -> master)
//   rptr            binary read pointer                (slave -> master)
//   rptr_gray       Gray read pointer                  (slave -> master)
//   f_empty         FIFO empty                         (slave -> master)
//   f_aempty        FIFO almost empty                  (slave -> master)
//   rd_count        read-side occupancy                (slave -> master)
//   rd_valid        RAM data valid pulse               (slave -> master)
//   underflow       sticky read-while-empty flag       (slave -> master)
interface rd_ptr_ctrl_if #(
    parameter int ADDR_WIDTH = 9
);
    logic                  r_en;
    logic [ADDR_WIDTH:0]   wptr_gray_sync;
    logic                  clr_err;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [ADDR_WIDTH:0]   rptr;
    logic [ADDR_WIDTH:0]   rptr_gray;
    logic                  f_empty;
    logic                  f_aempty;
    logic [ADDR_WIDTH:0]   rd_count;
    logic                  rd_valid;
    logic                  underflow;

    modport master (
        output r_en, wptr_gray_sync, clr_err,
        input  raddr, rptr, rptr_gray, f_empty, f_aempty, rd_count, rd_valid, underflow
    );

    modport slave (
        input  r_en, wptr_gray_sync, clr_err,
        output raddr, rptr, rptr_gray, f_empty, f_aempty, rd_count, rd_valid, underflow
    );
endinterface

// File: rtl/rd_ptr_ctrl.sv
// rtl/rd_ptr_ctrl.sv - async FIFO read-pointer controller with empty/almost-empty flags
//
// Purpose: keeps the binary and Gray read pointers of an asynchronous FIFO,
// derives empty / almost-empty / occupancy from the synchronised Gray write
// pointer, issues a one-cycle-latency data-valid pulse for a synchronous-read
// RAM and records reads attempted while empty.
// Ports:
//   r_clk  read-domain clock
//   rrst   synchronous active-low reset
//   bus    rd_ptr_ctrl_if.slave (request, write pointer, status, pointers)
module rd_ptr_ctrl #(
    parameter int ADDR_WIDTH    = 9,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic             r_clk,
    input  logic             rrst,
    rd_ptr_ctrl_if.slave     bus
);
    localparam int               PW       = ADDR_WIDTH + 1;
    localparam logic [PW-1:0]    C_THRESH = PW'(AEMPTY_THRESH);

    logic [PW-1:0] r_rptr;
    logic [PW-1:0] r_rptr_gray;
    logic          r_f_empty;
    logic          r_f_aempty;
    logic          r_rd_valid;
    logic          r_underflow;

    logic          w_rd_acc;
    logic [PW-1:0] w_rptr_next;
    logic [PW-1:0] w_rgray_next;
    logic [PW-1:0] w_wbin_sync;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Acceptance uses the registered empty flag so the pointer path never
    // depends combinationally on the incoming write pointer.
    assign w_rd_acc     = bus.r_en & ~r_f_empty;
    assign w_rptr_next  = r_rptr + PW'(w_rd_acc);
    assign w_rgray_next = (w_rptr_next >> 1) ^ w_rptr_next;
    assign w_wbin_sync  = gray2bin(bus.wptr_gray_sync);

    always_ff @(posedge r_clk) begin
        if (!rrst) begin
            r_rptr      <= '0;
            r_rptr_gray <= '0;
            r_f_empty   <= 1'b1;
            r_f_aempty  <= 1'b1;
            r_rd_valid  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_rptr      <= w_rptr_next;
            r_rptr_gray <= w_rgray_next;
            // Flags look ahead at the next pointer so empty asserts right
            // after the last read instead of one cycle later.
            r_f_empty   <= (w_rgray_next == bus.wptr_gray_sync);
            r_f_aempty  <= ((w_wbin_sync - w_rptr_next) <= C_THRESH);
            r_rd_valid  <= w_rd_acc;
            // A new underflow event outranks a simultaneous clear.
            if (bus.r_en && r_f_empty) begin
                r_underflow <= 1'b1;
            end else if (bus.clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign bus.rptr      = r_rptr;
    assign bus.raddr     = r_rptr[ADDR_WIDTH-1:0];
    assign bus.rptr_gray = r_rptr_gray;
    assign bus.f_empty   = r_f_empty;
    assign bus.f_aempty  = r_f_aempty;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.underflow = r_underflow;
    // The synchronised write pointer can only lag, so this never overstates.
    assign bus.rd_count  = w_wbin_sync - r_rptr;
endmodule

// File: tb/tb_rd_ptr_ctrl.sv
// tb/tb_rd_ptr_ctrl.sv - directed table-driven bench for rd_ptr_ctrl
module tb_rd_ptr_ctrl;
    localparam int AW = 4;

    logic clk;
    logic rrst;
    int   n_cmp;
    int   n_bad;

    rd_ptr_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    rd_ptr_ctrl #(.ADDR_WIDTH(AW), .AEMPTY_THRESH(2)) dut (
        .r_clk (clk),
        .rrst  (rrst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       ren;
        logic       clr;
        logic [4:0] wg;
        logic [4:0] e_rptr;
        logic [4:0] e_gray;
        logic       e_empty;
        logic       e_aempty;
        logic       e_valid;
        logic       e_under;
        logic [4:0] e_count;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst_n, input logic ren, input logic clr, input logic [4:0] wg,
                       input logic [4:0] e_rptr, input logic [4:0] e_gray, input logic e_empty,
                       input logic e_aempty, input logic e_valid, input logic e_under,
                       input logic [4:0] e_count);
        vec_t v;
        v.rst_n = rst_n; v.ren = ren; v.clr = clr; v.wg = wg;
        v.e_rptr = e_rptr; v.e_gray = e_gray; v.e_empty = e_empty; v.e_aempty = e_aempty;
        v.e_valid = e_valid; v.e_under = e_under; v.e_count = e_count;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rst_n, input logic ren, input logic clr, input logic [4:0] wg);
        rrst               = rst_n;
        bus.r_en           = ren;
        bus.clr_err        = clr;
        bus.wptr_gray_sync = wg;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        drive(1'b0, 1'b0, 1'b0, 5'b00000);

        //   rst ren clr wg         rptr  gray     emp ae  val und count
        // reset with a pending read
        add(0, 1, 0, 5'b00000, 5'd0, 5'b00000, 1, 1, 0, 0, 5'd0);
        add(0, 1, 0, 5'b00000, 5'd0, 5'b00000, 1, 1, 0, 0, 5'd0);
        // drain three entries, then one rejected read
        add(1, 0, 0, 5'b00010, 5'd0, 5'b00000, 0, 0, 0, 0, 5'd3);
        add(1, 1, 0, 5'b00010, 5'd1, 5'b00001, 0, 1, 1, 0, 5'd2);
        add(1, 1, 0, 5'b00010, 5'd2, 5'b00011, 0, 1, 1, 0, 5'd1);
        add(1, 1, 0, 5'b00010, 5'd3, 5'b00010, 1, 1, 1, 0, 5'd0);
        add(1, 1, 0, 5'b00010, 5'd3, 5'b00010, 1, 1, 0, 1, 5'd0);
        // error clear, then clear racing a new underflow
        add(1, 0, 1, 5'b00010, 5'd3, 5'b00010, 1, 1, 0, 0, 5'd0);
        add(1, 1, 1, 5'b00010, 5'd3, 5'b00010, 1, 1, 0, 1, 5'd0);
        add(1, 0, 0, 5'b00010, 5'd3, 5'b00010, 1, 1, 0, 1, 5'd0);
        add(1, 0, 1, 5'b00010, 5'd3, 5'b00010, 1, 1, 0, 0, 5'd0);
        // almost-empty with five entries
        add(0, 0, 0, 5'b00000, 5'd0, 5'b00000, 1, 1, 0, 0, 5'd0);
        add(1, 0, 0, 5'b00111, 5'd0, 5'b00000, 0, 0, 0, 0, 5'd5);
        add(1, 1, 0, 5'b00111, 5'd1, 5'b00001, 0, 0, 1, 0, 5'd4);
        add(1, 0, 0, 5'b00111, 5'd1, 5'b00001, 0, 0, 0, 0, 5'd4);
        add(1, 1, 0, 5'b00111, 5'd2, 5'b00011, 0, 0, 1, 0, 5'd3);
        add(1, 1, 0, 5'b00111, 5'd3, 5'b00010, 0, 1, 1, 0, 5'd2);
        // reset mid-burst; first read after release is rejected
        add(0, 1, 0, 5'b00111, 5'd0, 5'b00000, 1, 1, 0, 0, 5'd5);
        add(1, 1, 0, 5'b00111, 5'd0, 5'b00000, 0, 0, 0, 1, 5'd5);
        add(1, 1, 1, 5'b00111, 5'd1, 5'b00001, 0, 0, 1, 0, 5'd4);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst_n, tbl[i].ren, tbl[i].clr, tbl[i].wg);
            tick();
            chk($sformatf("v%0d.rptr", i),      int'(bus.rptr),      int'(tbl[i].e_rptr));
            chk($sformatf("v%0d.raddr", i),     int'(bus.raddr),     int'(tbl[i].e_rptr[3:0]));
            chk($sformatf("v%0d.rptr_gray", i), int'(bus.rptr_gray), int'(tbl[i].e_gray));
            chk($sformatf("v%0d.f_empty", i),   int'(bus.f_empty),   int'(tbl[i].e_empty));
            chk($sformatf("v%0d.f_aempty", i),  int'(bus.f_aempty),  int'(tbl[i].e_aempty));
            chk($sformatf("v%0d.rd_valid", i),  int'(bus.rd_valid),  int'(tbl[i].e_valid));
            chk($sformatf("v%0d.underflow", i), int'(bus.underflow), int'(tbl[i].e_under));
            chk($sformatf("v%0d.rd_count", i),  int'(bus.rd_count),  int'(tbl[i].e_count));
        end

        // pointer wrap: walk to 15, then step 15 -> 16 -> 17
        drive(1'b0, 1'b0, 1'b0, 5'b00000);
        tick();
        drive(1'b1, 1'b0, 1'b0, 5'b01000);
        tick();
        drive(1'b1, 1'b1, 1'b0, 5'b01000);
        repeat (15) tick();
        chk("wrap.rptr15",  int'(bus.rptr),      15);
        chk("wrap.gray15",  int'(bus.rptr_gray), 5'b01000);
        chk("wrap.empty15", int'(bus.f_empty),   1);
        drive(1'b1, 1'b0, 1'b0, 5'b11001);
        tick();
        chk("wrap.empty_pre", int'(bus.f_empty),  0);
        chk("wrap.count_pre", int'(bus.rd_count), 2);
        drive(1'b1, 1'b1, 1'b0, 5'b11001);
        tick();
        chk("wrap.rptr16",  int'(bus.rptr),      16);
        chk("wrap.gray16",  int'(bus.rptr_gray), 5'b11000);
        chk("wrap.raddr16", int'(bus.raddr),     0);
        chk("wrap.empty16", int'(bus.f_empty),   0);
        tick();
        chk("wrap.rptr17",  int'(bus.rptr),      17);
        chk("wrap.gray17",  int'(bus.rptr_gray), 5'b11001);
        chk("wrap.raddr17", int'(bus.raddr),     1);
        chk("wrap.empty17", int'(bus.f_empty),   1);
        chk("wrap.valid17", int'(bus.rd_valid),  1);

        // full occupancy and read racing a write-pointer step
        drive(1'b0, 1'b0, 1'b0, 5'b00000);
        tick();
        drive(1'b1, 1'b0, 1'b0, 5'b11000);
        tick();
        chk("full.count",  int'(bus.rd_count), 16);
        chk("full.empty",  int'(bus.f_empty),  0);
        chk("full.aempty", int'(bus.f_aempty), 0);
        drive(1'b1, 1'b1, 1'b0, 5'b11001);
        tick();
        chk("race.count",  int'(bus.rd_count), 16);
        chk("race.rptr",   int'(bus.rptr),     1);
        chk("race.empty",  int'(bus.f_empty),  0);
        chk("race.valid",  int'(bus.rd_valid), 1);
        drive(1'b1, 1'b0, 1'b0, 5'b11001);
        tick();
        chk("race.valid_drop", int'(bus.rd_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
